// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate-generation stage between decode and
// the ALU operand mux. Selects an immediate field width, sign- or zero-extends
// it to DATA_W, and merges a pending IMM-prefix into the next immediate so
// that full-width constants can be built from two instructions.
//
// Optional build macro: IMMEXT_SCALE_EN adds a 0-3 bit left shift of the
// result by in_scale (word/dword-scaled branch offsets). Without it in_scale
// is ignored.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             synchronous flush: drops held result and pending prefix
//   in_valid/in_ready request handshake
//   in_imm            raw immediate bits, LSB-aligned
//   in_sel            0=FIELD_A, 1=FIELD_B, 2=FIELD_C, 3=full IMM_W
//   in_sign           1=sign-extend, 0=zero-extend
//   in_prefix         request is an IMM prefix (produces no output beat)
//   in_scale          left shift amount (IMMEXT_SCALE_EN only)
//   out_valid/out_ready result handshake, one-entry output register
//   out_imm           extended immediate
//   out_prefixed      result was built from a prefix
module imm_extend_pipe #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned IMM_W     = 12,
    parameter int unsigned FIELD_A_W = 6,
    parameter int unsigned FIELD_B_W = 9,
    parameter int unsigned FIELD_C_W = 12,
    parameter int unsigned PFX_LOW_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_sel,
    input  logic              in_sign,
    input  logic              in_prefix,
    input  logic [1:0]        in_scale,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_prefixed
);

    localparam int unsigned PFX_W = DATA_W - PFX_LOW_W;
    localparam int unsigned EXT_W = (DATA_W > IMM_W) ? DATA_W : IMM_W;
    localparam int unsigned IDX_W = $clog2(EXT_W + 1);

    logic              pfx_valid;
    logic [PFX_W-1:0]  pfx_reg;

    logic              accept;
    logic              load;
    logic [IDX_W-1:0]  field_w;
    logic [EXT_W-1:0]  imm_wide;
    logic [EXT_W-1:0]  field_mask;
    logic [EXT_W-1:0]  ext_wide;
    logic              field_msb;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] result;

    logic              out_valid_n;
    logic [DATA_W-1:0] out_imm_n;
    logic              out_prefixed_n;
    logic              pfx_valid_n;
    logic [PFX_W-1:0]  pfx_reg_n;

    // Handshake: flush blocks acceptance so a coincident request is dropped.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && !in_prefix;

    // Field width selected by the request.
    always_comb begin
        field_w = IDX_W'(IMM_W);
        case (in_sel)
            2'd0:    field_w = IDX_W'(FIELD_A_W);
            2'd1:    field_w = IDX_W'(FIELD_B_W);
            2'd2:    field_w = IDX_W'(FIELD_C_W);
            default: field_w = IDX_W'(IMM_W);
        endcase
    end

    // Extension. A shift by the full EXT_W wraps to zero, so the minus-one
    // still yields an all-ones mask for the widest field. The field MSB is
    // isolated as the top set bit of the mask, avoiding a variable index.
    always_comb begin
        imm_wide   = EXT_W'(in_imm);
        field_mask = (EXT_W'(1) << field_w) - EXT_W'(1);
        field_msb  = |(imm_wide & (field_mask ^ (field_mask >> 1)));
        ext_wide   = imm_wide & field_mask;
        if (in_sign && field_msb) begin
            ext_wide = ext_wide | ~field_mask;
        end
    end

    // Prefix merge overrides the selected extension.
    assign merged = {pfx_reg, in_imm[PFX_LOW_W-1:0]};
    assign base   = pfx_valid ? merged : DATA_W'(ext_wide);

`ifdef IMMEXT_SCALE_EN
    assign result = base << in_scale;
`else
    logic unused_scale;
    assign unused_scale = ^in_scale;
    assign result       = base;
`endif

    // Next-state for the output register and prefix holding register.
    always_comb begin
        out_valid_n    = out_valid;
        out_imm_n      = out_imm;
        out_prefixed_n = out_prefixed;
        pfx_valid_n    = pfx_valid;
        pfx_reg_n      = pfx_reg;

        if (flush) begin
            out_valid_n = 1'b0;
            pfx_valid_n = 1'b0;
        end else if (load) begin
            out_valid_n    = 1'b1;
            out_imm_n      = result;
            out_prefixed_n = pfx_valid;
            pfx_valid_n    = 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_n = 1'b0;
            end
            if (accept) begin
                pfx_valid_n = 1'b1;
                pfx_reg_n   = in_imm[PFX_W-1:0];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_prefixed <= 1'b0;
            pfx_valid    <= 1'b0;
            pfx_reg      <= '0;
        end else begin
            out_valid    <= out_valid_n;
            out_imm      <= out_imm_n;
            out_prefixed <= out_prefixed_n;
            pfx_valid    <= pfx_valid_n;
            pfx_reg      <= pfx_reg_n;
        end
    end

endmodule
